// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-side controller for the dual-port-RAM FIFO.
// Pops FIFO words into a 4-entry buffer and presents them on a valid/ready
// stream. The pop decision reserves a buffer slot for the word in flight,
// so the buffer cannot overflow and m_ready never reaches fifo_rd_en.
`timescale 1ns/1ps
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pop_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [DATA_WIDTH-1:0] entry [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            count;
    logic                  inflight;
    logic                  pop;
    logic                  deq;
    logic [2:0]            occupancy;

    // Slots already committed: buffered words plus the one the FIFO is returning.
    assign occupancy = count + {2'b00, inflight};

    // Pop uses only registered state, enable, flush and fifo_empty.
    always_comb begin
        pop = (state == RUN) && enable && !fifo_empty && !flush && (occupancy < 3'd4);
    end

    assign fifo_rd_en = pop;
    assign fifo_rd_cs = pop;
    assign m_valid    = (count != 3'd0) && !flush;
    assign deq        = m_valid && m_ready;
    assign m_data     = entry[rd_ptr];
    assign busy       = (state != IDLE);

    // Next-state logic; flush overrides the normal transitions.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            if (state == DRAIN)
                state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state_nxt = RUN;
                RUN:     if (!enable) state_nxt = DRAIN;
                DRAIN: begin
                    if (enable)
                        state_nxt = RUN;
                    else if (!inflight && (count == 3'd0))
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Buffer storage, pointers, occupancy and in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                entry[i] <= '0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            inflight <= 1'b0;
        end else if (flush) begin
            // The word returning from last cycle's pop is dropped here.
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= pop;
            if (inflight) begin
                entry[wr_ptr] <= fifo_data;
                wr_ptr        <= wr_ptr + 2'd1;
            end
            if (deq)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, inflight} - {2'b00, deq};
        end
    end

    // Free-running pop statistics; survives flush, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pop_count <= '0;
        else if (pop)
            pop_count <= pop_count + 1'b1;
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a small registered-read FIFO model.
// Inputs change on the falling edge; outputs are checked 1ns later.
`timescale 1ns/1ps
module tb_fifo_drain_ctrl;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flush;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_cs;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic [CW-1:0] pop_count;

    logic [DW-1:0] mem [64];
    int            head;
    int            tail;
    logic          force_empty;

    int total = 0;
    int bad   = 0;
    int got_q [$];
    int saw_rd;

    always #5 clk = ~clk;

    fifo_drain_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_cs (fifo_rd_cs),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .pop_count  (pop_count)
    );

    // FIFO model: read data registered on the pop edge.
    assign fifo_empty = (head == tail) || force_empty;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= 0;
            fifo_data <= '0;
        end else if (fifo_rd_en) begin
            fifo_data <= mem[head[5:0]];
            head      <= head + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input int v);
        mem[tail[5:0]] = v[DW-1:0];
        tail++;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic grab();
        if (m_valid && m_ready)
            got_q.push_back(int'(m_data));
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        enable      = 1'b0;
        flush       = 1'b0;
        m_ready     = 1'b0;
        force_empty = 1'b0;
        tail        = 0;
        got_q.delete();
        nxt();
        nxt();
        rst = 1'b0;
        #1;
    endtask

    task automatic chk_words(input string tag, input int n, input int base);
        chk({tag, "_n"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), got_q[i], base + i);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_rd_cs", fifo_rd_cs, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_popcnt", pop_count, 0);

        // Basic: 4 words, m_ready high; pops cycles 1-4, stream cycles 3-6
        for (int i = 0; i < 4; i++) push(i);
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            nxt(); #1;
            chk($sformatf("s1_rd_en%0d", c), fifo_rd_en, (c <= 4));
            chk($sformatf("s1_rd_cs%0d", c), fifo_rd_cs, (c <= 4));
            chk($sformatf("s1_valid%0d", c), m_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6)
                chk($sformatf("s1_data%0d", c), m_data, c - 3);
        end
        chk("s1_popcnt", pop_count, 4);
        chk("s1_busy", busy, 1);

        // Consumer stall: 6 words, only 4 pops until first dequeue
        do_reset();
        for (int i = 0; i < 6; i++) push(10 + i);
        enable = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            nxt(); #1;
            chk($sformatf("s2_rd_en%0d", c), fifo_rd_en, (c <= 4));
        end
        chk("s2_head", m_data, 10);
        m_ready = 1'b1;
        #1;
        chk("s2_no_ready_path", fifo_rd_en, 0);
        grab();
        nxt(); #1;
        chk("s2_resume", fifo_rd_en, 1);
        grab();
        for (int c = 10; c <= 25; c++) begin
            nxt(); #1;
            grab();
        end
        chk_words("s2", 6, 10);
        chk("s2_popcnt", pop_count, 6);

        // Drain: enable drops with count=2 and one word in flight
        do_reset();
        for (int i = 0; i < 5; i++) push(20 + i);
        enable = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            nxt(); #1;
            chk($sformatf("s3_rd_en%0d", c), fifo_rd_en, 1);
        end
        nxt();
        enable = 1'b0;
        #1;
        chk("s3_stop", fifo_rd_en, 0);
        chk("s3_valid", m_valid, 1);
        nxt(); #1;
        chk("s3_drain_busy", busy, 1);
        m_ready = 1'b1;
        #1;
        grab();
        saw_rd = 0;
        for (int c = 0; c < 12; c++) begin
            nxt(); #1;
            if (fifo_rd_en) saw_rd++;
            if (!busy) break;
            grab();
        end
        chk("s3_idle", busy, 0);
        chk("s3_no_pops", saw_rd, 0);
        chk_words("s3", 3, 20);
        chk("s3_popcnt", pop_count, 3);

        // Flush the cycle after a pop
        do_reset();
        for (int i = 0; i < 4; i++) push(40 + i);
        enable = 1'b1;
        nxt(); nxt(); nxt();
        flush = 1'b1;
        #1;
        chk("s4_fl_rd_en", fifo_rd_en, 0);
        chk("s4_fl_valid", m_valid, 0);
        chk("s4_fl_popcnt", pop_count, 2);
        nxt();
        flush = 1'b0;
        #1;
        chk("s4_valid_c4", m_valid, 0);
        chk("s4_rd_en_c4", fifo_rd_en, 1);
        chk("s4_popcnt_c4", pop_count, 2);
        chk("s4_busy", busy, 1);
        nxt(); #1;
        chk("s4_valid_c5", m_valid, 0);
        nxt(); #1;
        chk("s4_valid_c6", m_valid, 1);
        chk("s4_data_c6", m_data, 42);

        // FIFO empty in odd cycles, m_ready high
        do_reset();
        for (int i = 0; i < 6; i++) push(30 + i);
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            nxt();
            force_empty = (c % 2 == 1);
            #1;
            chk($sformatf("s5_rd_en%0d", c), fifo_rd_en, (c % 2 == 0 && c <= 12));
            grab();
        end
        chk_words("s5", 6, 30);

        // pop_count wrap with a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) push(i);
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            nxt(); #1;
            if (c == 16) chk("s6_cnt15", pop_count, 15);
            if (c == 17) chk("s6_cnt0", pop_count, 0);
            if (c == 18) chk("s6_cnt1", pop_count, 1);
        end

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 6; i++) push(50 + i);
        m_ready = 1'b1;
        enable  = 1'b1;
        nxt(); nxt(); nxt(); nxt();
        #1;
        chk("s7_pre_valid", m_valid, 1);
        rst = 1'b1;
        #1;
        chk("s7_rd_en", fifo_rd_en, 0);
        chk("s7_valid", m_valid, 0);
        chk("s7_busy", busy, 0);
        chk("s7_popcnt", pop_count, 0);
        chk("s7_data", m_data, 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
